// File: rtl/reorder_buffer_if.sv
// Bundles the issue, CDB, forwarding, commit and flush signals of the
// reorder buffer. The ROB uses the slave modport. The issue stage, the
// functional units and the register file together form the master side.
//
// Handshake: an instruction is accepted at a rising clock edge exactly when
// issue_valid_in and ready_out are both 1, and it receives index
// issue_idx_out. cdb_valid_in is a one-cycle pulse with no back-pressure.
// commit_* and flush_* are one-cycle strobes driven from registers.
interface reorder_buffer_if #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
);
  logic                issue_valid_in;
  logic [4:0]          issue_rd_in;
  logic                issue_we_in;
  logic                ready_out;
  logic [IDX_W-1:0]    issue_idx_out;

  logic                cdb_valid_in;
  logic [IDX_W-1:0]    cdb_idx_in;
  logic signed [31:0]  cdb_data_in;
  logic                cdb_mispredict_in;
  logic [31:0]         cdb_target_in;

  logic [IDX_W-1:0]    q1_idx_in;
  logic [IDX_W-1:0]    q2_idx_in;
  logic                q1_ready_out;
  logic                q2_ready_out;
  logic signed [31:0]  q1_data_out;
  logic signed [31:0]  q2_data_out;

  logic                commit_we_out;
  logic [4:0]          commit_wa_out;
  logic signed [31:0]  commit_wd_out;
  logic [IDX_W-1:0]    commit_rob_ix_out;

  logic                flush_out;
  logic [DEPTH-1:0]    flush_addrs_out;
  logic [31:0]         redirect_pc_out;
  logic [IDX_W:0]      count_out;

  modport slave (
    input  issue_valid_in, issue_rd_in, issue_we_in,
    output ready_out, issue_idx_out,
    input  cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
    input  q1_idx_in, q2_idx_in,
    output q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
    output commit_we_out, commit_wa_out, commit_wd_out, commit_rob_ix_out,
    output flush_out, flush_addrs_out, redirect_pc_out, count_out
  );

  modport master (
    output issue_valid_in, issue_rd_in, issue_we_in,
    input  ready_out, issue_idx_out,
    output cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
    output q1_idx_in, q2_idx_in,
    input  q1_ready_out, q2_ready_out, q1_data_out, q2_data_out,
    input  commit_we_out, commit_wa_out, commit_wd_out, commit_rob_ix_out,
    input  flush_out, flush_addrs_out, redirect_pc_out, count_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates indices at issue, captures out-of-order
// CDB results, retires in program order (one per cycle) and squashes younger
// entries when a mispredicted branch retires.
// Optional macro ROB_PERF_EN adds retire/flush performance counters.
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic clk_in,
  input  logic rst_in,
`ifdef ROB_PERF_EN
  output logic [31:0] perf_commits_out,
  output logic [31:0] perf_flushes_out,
`endif
  reorder_buffer_if.slave bus
);

  // Per-entry state
  logic [DEPTH-1:0]   busy_q, done_q, we_q, mis_q;
  logic [4:0]         rd_q     [DEPTH];
  logic signed [31:0] data_q   [DEPTH];
  logic [31:0]        target_q [DEPTH];

  // Pointers and occupancy
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  // Registered commit/flush outputs
  logic               commit_we_q;
  logic [4:0]         commit_wa_q;
  logic signed [31:0] commit_wd_q;
  logic [IDX_W-1:0]   commit_ix_q;
  logic               flush_q;
  logic [DEPTH-1:0]   flush_addrs_q;
  logic [31:0]        redirect_q;

  // Per-cycle decisions
  logic             retire, flush_fire, ready, issue_fire, cdb_fire, issue_we_eff;
  logic [DEPTH-1:0] flush_mask;

  // Retire/issue/CDB decisions and next pointer/count values
  always_comb begin
    retire       = busy_q[head_q] & done_q[head_q];
    flush_fire   = retire & mis_q[head_q];
    ready        = (count_q < (IDX_W+1)'(DEPTH)) && !flush_fire;
    issue_fire   = bus.issue_valid_in & ready;
    issue_we_eff = bus.issue_we_in & (bus.issue_rd_in != 5'd0);
    cdb_fire     = bus.cdb_valid_in & busy_q[bus.cdb_idx_in] &
                   ~done_q[bus.cdb_idx_in] & ~flush_fire;
    // Everything still busy except the retiring branch itself is squashed
    flush_mask   = busy_q & ~(DEPTH'(1) << head_q);

    head_d  = retire ? head_q + IDX_W'(1) : head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_fire) begin
      tail_d  = head_q + IDX_W'(1);
      count_d = '0;
    end else begin
      if (issue_fire) tail_d = tail_q + IDX_W'(1);
      count_d = count_q + (IDX_W+1)'(issue_fire) - (IDX_W+1)'(retire);
    end
  end

  // Pointer, count and registered output updates
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commit_we_q   <= 1'b0;
      commit_wa_q   <= '0;
      commit_wd_q   <= '0;
      commit_ix_q   <= '0;
      flush_q       <= 1'b0;
      flush_addrs_q <= '0;
      redirect_q    <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commit_we_q   <= retire & we_q[head_q];
      flush_q       <= flush_fire;
      flush_addrs_q <= flush_fire ? flush_mask : '0;
      redirect_q    <= flush_fire ? target_q[head_q] : 32'd0;
      if (retire) begin
        commit_wa_q <= rd_q[head_q];
        commit_wd_q <= data_q[head_q];
        commit_ix_q <= head_q;
      end
    end
  end

  // Entry array: allocate at tail, complete from CDB, free at head or on squash
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      done_q <= '0;
      we_q   <= '0;
      mis_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]     <= '0;
        data_q[i]   <= '0;
        target_q[i] <= '0;
      end
    end else if (flush_fire) begin
      busy_q <= '0;
      done_q <= '0;
      mis_q  <= '0;
    end else begin
      if (retire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
      end
      if (issue_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        we_q[tail_q]   <= issue_we_eff;
        rd_q[tail_q]   <= bus.issue_rd_in;
        mis_q[tail_q]  <= 1'b0;
      end
      if (cdb_fire) begin
        done_q[bus.cdb_idx_in]   <= 1'b1;
        data_q[bus.cdb_idx_in]   <= bus.cdb_data_in;
        mis_q[bus.cdb_idx_in]    <= bus.cdb_mispredict_in;
        target_q[bus.cdb_idx_in] <= bus.cdb_target_in;
      end
    end
  end

  // Operand forwarding: CDB bypass first, then completed entry, else nothing
  always_comb begin
    bus.q1_ready_out = 1'b0;
    bus.q1_data_out  = '0;
    bus.q2_ready_out = 1'b0;
    bus.q2_data_out  = '0;
    if (bus.cdb_valid_in && bus.cdb_idx_in == bus.q1_idx_in) begin
      bus.q1_ready_out = 1'b1;
      bus.q1_data_out  = bus.cdb_data_in;
    end else if (busy_q[bus.q1_idx_in] && done_q[bus.q1_idx_in]) begin
      bus.q1_ready_out = 1'b1;
      bus.q1_data_out  = data_q[bus.q1_idx_in];
    end
    if (bus.cdb_valid_in && bus.cdb_idx_in == bus.q2_idx_in) begin
      bus.q2_ready_out = 1'b1;
      bus.q2_data_out  = bus.cdb_data_in;
    end else if (busy_q[bus.q2_idx_in] && done_q[bus.q2_idx_in]) begin
      bus.q2_ready_out = 1'b1;
      bus.q2_data_out  = data_q[bus.q2_idx_in];
    end
  end

  assign bus.ready_out         = ready;
  assign bus.issue_idx_out     = tail_q;
  assign bus.commit_we_out     = commit_we_q;
  assign bus.commit_wa_out     = commit_wa_q;
  assign bus.commit_wd_out     = commit_wd_q;
  assign bus.commit_rob_ix_out = commit_ix_q;
  assign bus.flush_out         = flush_q;
  assign bus.flush_addrs_out   = flush_addrs_q;
  assign bus.redirect_pc_out   = redirect_q;
  assign bus.count_out         = count_q;

`ifdef ROB_PERF_EN
  logic [31:0] perf_commits_q, perf_flushes_q;

  // Free-running retire and flush counters, wrapping at 2^32
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      perf_commits_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      if (retire)     perf_commits_q <= perf_commits_q + 32'd1;
      if (flush_fire) perf_flushes_q <= perf_flushes_q + 32'd1;
    end
  end

  assign perf_commits_out = perf_commits_q;
  assign perf_flushes_out = perf_flushes_q;
`endif

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer sitting directly downstream of the functional units' result bus and upstream of the register file write port.
- Allocates a 3-bit ROB index per issued instruction, captures out-of-order results, and retires them in program order.
- Supplies operand forwarding to reservation stations and drives the register file's `wa`/`we`/`wd`/`rob_ix` and `flush`/`flush_addrs` inputs.
- On a mispredicted branch reaching the head, squashes all younger entries and redirects fetch.

Parameters:
- DEPTH, 8, number of entries; power of two.
- IDX_W, 3, log2(DEPTH); width of ROB indices.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- issue_valid_in  input  1  issue stage presents an instruction
- issue_rd_in  input  5  destination register
- issue_we_in  input  1  instruction writes `rd` (0 for store/branch/NOP; forced 0 when `rd`=0)
- ready_out  output  1  an entry can be allocated this cycle
- issue_idx_out  output  IDX_W  index allocated if issue occurs (equals tail)
- cdb_valid_in  input  1  FU result valid (single-cycle pulse)
- cdb_idx_in  input  IDX_W  ROB index of result
- cdb_data_in  input  32 signed  result value
- cdb_mispredict_in  input  1  result is a mispredicted branch/jump
- cdb_target_in  input  32  correct next PC for mispredict
- q1_idx_in, q2_idx_in  input  IDX_W  operand tags looked up by issue
- q1_ready_out, q2_ready_out  output  1  tagged value available
- q1_data_out, q2_data_out  output  32 signed  tagged value
- commit_we_out  output  1  register write strobe
- commit_wa_out  output  5  register address
- commit_wd_out  output  32 signed  register data
- commit_rob_ix_out  output  IDX_W  retiring index (register file clears its tag only if matching)
- flush_out  output  1  squash pulse
- flush_addrs_out  output  DEPTH  one-hot mask of squashed indices
- redirect_pc_out  output  32  fetch redirect target, valid with `flush_out`
- count_out  output  IDX_W+1  occupied entries

Behaviour:
- Reset (async):
  - head=tail=count=0.
  - All entries busy=0, done=0, mispredict=0.
  - All registered outputs 0.
  - `ready_out`=1 once reset deasserts.
- Entry fields: busy, done, we, rd, data[31:0], mispredict, target[31:0].
- `ready_out` = (count<DEPTH) and not (head busy & done & mispredict). Combinational from state.
- Issue (`issue_valid_in` & `ready_out` at edge):
  - entry[tail] ← busy=1, done=0, we, rd, mispredict=0.
  - tail wraps DEPTH-1→0.
  - Issue while not ready is dropped silently.
- CDB write at edge:
  - If entry[cdb_idx_in].busy and not done: data, mispredict, target written; done=1.
  - CDB to a non-busy or already-done entry is ignored.
- Commit decision is registered:
  - If entry[head] busy & done at an edge, it retires at that edge: busy cleared, head advances.
  - `commit_we_out`=we, `commit_wa_out`, `commit_wd_out`, `commit_rob_ix_out` valid in the following cycle only.
  - `commit_we_out`=0 in any cycle without retirement.
- Latency: CDB in cycle N → done at end of N → retire at end of N+1 → commit outputs visible in cycle N+2. At most one retire per cycle.
- Count = count + issue − retire. Issue and retire in the same cycle leaves count unchanged. A full buffer does not accept issue in the cycle it retires.
- Forwarding (combinational): `qX_ready_out` = (entry busy & done) or (`cdb_valid_in` & `cdb_idx_in`==`qX_idx_in`). Data comes from the CDB bypass when matching, otherwise from the entry. Non-busy tag → ready 0, data 0.
- Mispredict retire: head entry done with mispredict=1 retires normally (link register write proceeds), and at the same edge:
  - `flush_addrs_out` ← mask of all other busy entries; `flush_out` ← 1; `redirect_pc_out` ← target (one cycle).
  - All entries cleared; tail ← head+1; head ← head+1; count ← 0.
  - Issue and CDB writes at that edge are discarded.
- Empty: no retire; `commit_*` and `flush_out` stay 0.

Optional Feature:
- `ROB_PERF_EN`: when defined, adds output ports `perf_commits_out` (32-bit retired count) and `perf_flushes_out` (32-bit flush count). Both are asynchronously reset to 0, increment on each retire/flush, and wrap at 2^32.
- When undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset mid-operation with 5 entries busy → next cycle `count_out`=0, `ready_out`=1, `commit_we_out`=0, `issue_idx_out`=0.
- Issue `rd`=5,6,7 (idx 0,1,2); CDB idx2=30, then idx0=10, then idx1=20 → commits in order (x5=10, x6=20, x7=30) on three consecutive cycles; idx0 commit appears 2 cycles after its CDB pulse.
- Issue 8 → `ready_out`=0, 9th issue dropped; CDB idx0, retire with simultaneous issue held off until count=7; tail wraps to idx0.
- Same-cycle CDB idx3=0xDEAD with `q1_idx_in`=3 → `q1_ready_out`=1, `q1_data_out`=0xDEAD combinationally.
- Issue branch at idx1 plus idx2..4; CDB idx1 mispredict target 0x100 after idx0 commits → `flush_out`=1, `flush_addrs_out`=8'b0001_1100, `redirect_pc_out`=0x100, `count_out`=0, next issue gets idx2.
- With `ROB_PERF_EN`: above flush sequence → `perf_flushes_out`=1, `perf_commits_out`=2.
